// File: rtl/data_bank_scheduler_pkg.sv
// Shared types, widths and the wrap-aware issue-id age comparison used by the
// data bank scheduler and its per-bank arbiters.
package data_bank_scheduler_pkg;

  localparam int CONFLICT_WIDTH = 16;
  localparam int ADDR_WIDTH     = 30;
  localparam int DATA_WIDTH     = 32;
  localparam int MAX_ID_WIDTH   = 32;
  localparam int PORT_IDX_WIDTH = 8;

  typedef struct packed {
    logic                  wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } bank_req_t;

  typedef struct packed {
    logic                      valid;
    logic [PORT_IDX_WIDTH-1:0] port;
  } resp_pipe_t;

  // a is older than b when (a - b) mod 2^width has its top bit set
  function automatic logic id_older(input logic [MAX_ID_WIDTH-1:0] a,
                                    input logic [MAX_ID_WIDTH-1:0] b,
                                    input int unsigned width);
    logic [MAX_ID_WIDTH-1:0] diff;
    diff = a - b;
    return diff[width-1];
  endfunction

endpackage

// File: rtl/data_bank_scheduler_if.sv
// Requester and bank-memory signal bundle for the data bank scheduler.
// The master side is the requesters plus memory; the slave side is the scheduler.
interface data_bank_scheduler_if #(
  parameter int NUM_PORTS  = 4,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 256,
  parameter int ID_WIDTH   = 6
);

  localparam int AW = $clog2(BANK_DEPTH);

  logic                req_valid  [NUM_PORTS];
  logic [ID_WIDTH-1:0] req_id     [NUM_PORTS];
  logic [29:0]         req_addr   [NUM_PORTS];
  logic                req_wen    [NUM_PORTS];
  logic [31:0]         req_wdata  [NUM_PORTS];
  logic                req_ready  [NUM_PORTS];
  logic                resp_valid [NUM_PORTS];
  logic [31:0]         resp_rdata [NUM_PORTS];

  logic                bank_en    [NUM_BANKS];
  logic                bank_wen   [NUM_BANKS];
  logic [AW-1:0]       bank_addr  [NUM_BANKS];
  logic [31:0]         bank_wdata [NUM_BANKS];
  logic [31:0]         bank_rdata [NUM_BANKS];

  modport master (
    output req_valid, req_id, req_addr, req_wen, req_wdata, bank_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  bank_en, bank_wen, bank_addr, bank_wdata
  );

  modport slave (
    input  req_valid, req_id, req_addr, req_wen, req_wdata, bank_rdata,
    output req_ready, resp_valid, resp_rdata,
    output bank_en, bank_wen, bank_addr, bank_wdata
  );

endinterface

// File: rtl/data_bank_scheduler_bank_age_arbiter.sv
// Single-bank arbiter: starved candidates win lowest-index first, otherwise the
// oldest issue id wins with ties going to the lowest port index.
module bank_age_arbiter
  import data_bank_scheduler_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 6
) (
  input  logic [NUM_PORTS-1:0] cand,
  input  logic [ID_WIDTH-1:0]  ids [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] starved,
  output logic [NUM_PORTS-1:0] grant
);

  logic [NUM_PORTS-1:0] hungry;
  logic                 found;
  int                   best;

  always_comb begin
    grant  = '0;
    found  = 1'b0;
    best   = 0;
    hungry = cand & starved;
    if (|hungry) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (hungry[p] && !found) begin
          grant[p] = 1'b1;
          found    = 1'b1;
        end
      end
    end else begin
      // strict "older" keeps the earlier port on equal ids
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (cand[p] && (!found || id_older(MAX_ID_WIDTH'(ids[p]),
                                           MAX_ID_WIDTH'(ids[best]),
                                           ID_WIDTH))) begin
          best  = p;
          found = 1'b1;
        end
      end
      if (found) grant[best] = 1'b1;
    end
  end

endmodule

// File: rtl/data_bank_scheduler.sv
// Age-ordered scheduler for the banked data memory: per-bank grant, one-cycle
// load return, starvation bound per port and per-bank conflict statistics.
module data_bank_scheduler
  import data_bank_scheduler_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int NUM_BANKS    = 4,
  parameter int BANK_DEPTH   = 256,
  parameter int ID_WIDTH     = 6,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  data_bank_scheduler_if.slave      bus,
  output logic [CONFLICT_WIDTH-1:0] conflict_cnt [NUM_BANKS]
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int AW        = $clog2(BANK_DEPTH);
  localparam int WAIT_W    = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0]     bank_of  [NUM_PORTS];
  logic [ID_WIDTH-1:0]       ids      [NUM_PORTS];
  logic [NUM_PORTS-1:0]      cand     [NUM_BANKS];
  logic [NUM_PORTS-1:0]      grant    [NUM_BANKS];
  logic [NUM_PORTS-1:0]      starved;
  logic [WAIT_W-1:0]         wait_cnt [NUM_PORTS];
  bank_req_t                 sel_req  [NUM_BANKS];
  logic [PORT_IDX_WIDTH-1:0] win_port [NUM_BANKS];
  resp_pipe_t                pipe     [NUM_BANKS];

  // reset gates candidacy, so every combinational output falls to 0 with it
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bank_of[p] = bus.req_addr[p] & ADDR_WIDTH'(NUM_BANKS - 1);
      ids[p]     = bus.req_id[p];
      starved[p] = (wait_cnt[p] == WAIT_W'(STARVE_LIMIT));
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      cand[b] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        cand[b][p] = rst_n && bus.req_valid[p] && (bank_of[p] == ADDR_WIDTH'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
    bank_age_arbiter #(
      .NUM_PORTS(NUM_PORTS),
      .ID_WIDTH (ID_WIDTH)
    ) u_arb (
      .cand   (cand[b]),
      .ids    (ids),
      .starved(starved),
      .grant  (grant[b])
    );
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      sel_req[b]  = '0;
      win_port[b] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant[b][p]) begin
          sel_req[b].wen   = bus.req_wen[p];
          sel_req[b].addr  = bus.req_addr[p];
          sel_req[b].wdata = bus.req_wdata[p];
          win_port[b]      = PORT_IDX_WIDTH'(p);
        end
      end
      bus.bank_en[b]    = |grant[b];
      bus.bank_wen[b]   = sel_req[b].wen;
      bus.bank_addr[b]  = AW'(sel_req[b].addr >> BANK_BITS);
      bus.bank_wdata[b] = sel_req[b].wdata;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.req_ready[p] = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        bus.req_ready[p] = bus.req_ready[p] | grant[b][p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) wait_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bus.req_ready[p] || !bus.req_valid[p]) begin
          wait_cnt[p] <= '0;
        end else if (wait_cnt[p] != WAIT_W'(STARVE_LIMIT)) begin
          wait_cnt[p] <= wait_cnt[p] + 1'b1;
        end
      end
    end
  end

  // each bank remembers which port its load belongs to for the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        pipe[b]         <= '0;
        conflict_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        pipe[b].valid <= bus.bank_en[b] && !bus.bank_wen[b];
        pipe[b].port  <= win_port[b];
        if (((cand[b] & (cand[b] - 1'b1)) != '0) && (conflict_cnt[b] != '1)) begin
          conflict_cnt[b] <= conflict_cnt[b] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.resp_valid[p] = 1'b0;
      bus.resp_rdata[p] = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rst_n && pipe[b].valid && (pipe[b].port == PORT_IDX_WIDTH'(p))) begin
          bus.resp_valid[p] = 1'b1;
          bus.resp_rdata[p] = bus.bank_rdata[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_bank_scheduler.sv
// Directed bench for data_bank_scheduler with a behavioural single-port
// memory model per bank; expected values are hand-computed per step.
module tb_data_bank_scheduler;
  import data_bank_scheduler_pkg::*;

  localparam int NUM_PORTS    = 4;
  localparam int NUM_BANKS    = 4;
  localparam int BANK_DEPTH   = 256;
  localparam int ID_WIDTH     = 6;
  localparam int STARVE_LIMIT = 15;

  logic clk;
  logic rst_n;
  logic [CONFLICT_WIDTH-1:0] conflict_cnt [NUM_BANKS];
  logic [31:0] mem [NUM_BANKS][BANK_DEPTH];
  logic [5:0]  sid [3];
  int total;
  int bad;

  data_bank_scheduler_if #(
    .NUM_PORTS (NUM_PORTS),
    .NUM_BANKS (NUM_BANKS),
    .BANK_DEPTH(BANK_DEPTH),
    .ID_WIDTH  (ID_WIDTH)
  ) bus ();

  data_bank_scheduler #(
    .NUM_PORTS   (NUM_PORTS),
    .NUM_BANKS   (NUM_BANKS),
    .BANK_DEPTH  (BANK_DEPTH),
    .ID_WIDTH    (ID_WIDTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int b, input int i);
    return 32'hA000_0000 | 32'(b << 8) | 32'(i);
  endfunction

  // memory model: writes land at the edge, reads appear the cycle after
  always @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bus.bank_en[b]) begin
        if (bus.bank_wen[b]) mem[b][bus.bank_addr[b]] <= bus.bank_wdata[b];
        else                 bus.bank_rdata[b] <= mem[b][bus.bank_addr[b]];
      end
    end
  end

  task automatic applyStimulus(input int port, input logic valid, input logic [5:0] id,
                               input logic [29:0] addr, input logic wen,
                               input logic [31:0] wdata);
    bus.req_valid[port] = valid;
    bus.req_id[port]    = id;
    bus.req_addr[port]  = addr;
    bus.req_wen[port]   = wen;
    bus.req_wdata[port] = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int i = 0; i < BANK_DEPTH; i++) mem[b][i] <= init_word(b, i);
    mem[1][1] <= 32'hDEAD_BEEF;
    for (int p = 0; p < NUM_PORTS; p++) applyStimulus(p, 1'b0, 6'd0, 30'd0, 1'b0, 32'd0);

    nextCycle();
    nextCycle();
    checkOutput("reset_resp_valid0", 32'(bus.resp_valid[0]), 32'd0);
    checkOutput("reset_resp_rdata0", bus.resp_rdata[0], 32'd0);
    checkOutput("reset_conflict0", 32'(conflict_cnt[0]), 32'd0);
    rst_n = 1'b1;

    // single load to addr 0x5 -> bank 1, index 1
    applyStimulus(0, 1'b1, 6'd0, 30'h5, 1'b0, 32'd0);
    #1;
    checkOutput("t1_ready0", 32'(bus.req_ready[0]), 32'd1);
    checkOutput("t1_bank_en1", 32'(bus.bank_en[1]), 32'd1);
    checkOutput("t1_bank_addr1", 32'(bus.bank_addr[1]), 32'd1);
    checkOutput("t1_bank_en0", 32'(bus.bank_en[0]), 32'd0);
    nextCycle();
    applyStimulus(0, 1'b0, 6'd0, 30'h5, 1'b0, 32'd0);
    #1;
    checkOutput("t1_resp_valid0", 32'(bus.resp_valid[0]), 32'd1);
    checkOutput("t1_resp_rdata0", bus.resp_rdata[0], 32'hDEAD_BEEF);
    checkOutput("t1_resp_rdata1_idle", bus.resp_rdata[1], 32'd0);
    nextCycle();
    checkOutput("t1_resp_valid0_after", 32'(bus.resp_valid[0]), 32'd0);

    // three loads to three different banks in one cycle
    applyStimulus(0, 1'b1, 6'd1, 30'h0, 1'b0, 32'd0);
    applyStimulus(1, 1'b1, 6'd2, 30'h1, 1'b0, 32'd0);
    applyStimulus(2, 1'b1, 6'd3, 30'h2, 1'b0, 32'd0);
    #1;
    checkOutput("t2_ready", 32'({bus.req_ready[2], bus.req_ready[1], bus.req_ready[0]}), 32'h7);
    nextCycle();
    for (int p = 0; p < 3; p++) applyStimulus(p, 1'b0, 6'd0, 30'd0, 1'b0, 32'd0);
    #1;
    checkOutput("t2_resp_valid", 32'({bus.resp_valid[2], bus.resp_valid[1], bus.resp_valid[0]}), 32'h7);
    checkOutput("t2_rdata0", bus.resp_rdata[0], init_word(0, 0));
    checkOutput("t2_rdata1", bus.resp_rdata[1], init_word(1, 0));
    checkOutput("t2_rdata2", bus.resp_rdata[2], init_word(2, 0));
    checkOutput("t2_conflicts", 32'({conflict_cnt[2], conflict_cnt[1]} | 32'(conflict_cnt[0])), 32'd0);

    // bank 3 conflict, id 5 (port1) older than id 7 (port0)
    applyStimulus(0, 1'b1, 6'd7, 30'h3, 1'b0, 32'd0);
    applyStimulus(1, 1'b1, 6'd5, 30'h7, 1'b0, 32'd0);
    #1;
    checkOutput("t3_ready_first", 32'({bus.req_ready[1], bus.req_ready[0]}), 32'h2);
    nextCycle();
    applyStimulus(1, 1'b0, 6'd0, 30'd0, 1'b0, 32'd0);
    #1;
    checkOutput("t3_ready_second", 32'(bus.req_ready[0]), 32'd1);
    checkOutput("t3_conflict3", 32'(conflict_cnt[3]), 32'd1);
    checkOutput("t3_rdata1", bus.resp_rdata[1], init_word(3, 1));
    nextCycle();
    applyStimulus(0, 1'b0, 6'd0, 30'd0, 1'b0, 32'd0);
    #1;
    checkOutput("t3_rdata0", bus.resp_rdata[0], init_word(3, 0));

    // id wrap: 62 is older than 1
    applyStimulus(0, 1'b1, 6'd62, 30'h6, 1'b0, 32'd0);
    applyStimulus(1, 1'b1, 6'd1, 30'hA, 1'b0, 32'd0);
    #1;
    checkOutput("t4_ready_wrap", 32'({bus.req_ready[1], bus.req_ready[0]}), 32'h1);
    nextCycle();
    applyStimulus(0, 1'b0, 6'd0, 30'd0, 1'b0, 32'd0);
    #1;
    checkOutput("t4_ready1", 32'(bus.req_ready[1]), 32'd1);
    checkOutput("t4_rdata0", bus.resp_rdata[0], init_word(2, 1));
    checkOutput("t4_conflict2", 32'(conflict_cnt[2]), 32'd1);
    nextCycle();
    applyStimulus(1, 1'b0, 6'd0, 30'd0, 1'b0, 32'd0);
    #1;
    checkOutput("t4_rdata1", bus.resp_rdata[1], init_word(2, 2));
    nextCycle();

    // starvation: ports 0-2 rotate with older ids, port3 (id 40) waits
    sid[0] = 6'd10;
    sid[1] = 6'd11;
    sid[2] = 6'd12;
    for (int p = 0; p < 3; p++) applyStimulus(p, 1'b1, sid[p], 30'(p * 4), 1'b0, 32'd0);
    applyStimulus(3, 1'b1, 6'd40, 30'd12, 1'b0, 32'd0);
    for (int k = 0; k < 16; k++) begin
      #1;
      checkOutput($sformatf("t5_ready3_k%0d", k), 32'(bus.req_ready[3]), 32'(k == 15));
      if (k < 15) checkOutput($sformatf("t5_rr_k%0d", k), 32'(bus.req_ready[k % 3]), 32'd1);
      nextCycle();
      if (k < 15) begin
        sid[k % 3] = sid[k % 3] + 6'd3;
        applyStimulus(k % 3, 1'b1, sid[k % 3], 30'((k % 3) * 4), 1'b0, 32'd0);
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) applyStimulus(p, 1'b0, 6'd0, 30'd0, 1'b0, 32'd0);
    #1;
    checkOutput("t5_conflict0", 32'(conflict_cnt[0]), 32'd16);
    nextCycle();

    // store then load to the same address on consecutive cycles
    applyStimulus(0, 1'b1, 6'd20, 30'h10, 1'b1, 32'h1234);
    #1;
    checkOutput("t6_store_ready", 32'(bus.req_ready[0]), 32'd1);
    checkOutput("t6_bank_wen0", 32'(bus.bank_wen[0]), 32'd1);
    checkOutput("t6_bank_addr0", 32'(bus.bank_addr[0]), 32'd4);
    checkOutput("t6_bank_wdata0", bus.bank_wdata[0], 32'h1234);
    nextCycle();
    applyStimulus(0, 1'b1, 6'd21, 30'h10, 1'b0, 32'd0);
    #1;
    checkOutput("t6_store_no_resp", 32'(bus.resp_valid[0]), 32'd0);
    checkOutput("t6_load_ready", 32'(bus.req_ready[0]), 32'd1);
    nextCycle();
    applyStimulus(0, 1'b0, 6'd0, 30'd0, 1'b0, 32'd0);
    #1;
    checkOutput("t6_load_valid", 32'(bus.resp_valid[0]), 32'd1);
    checkOutput("t6_load_rdata", bus.resp_rdata[0], 32'h1234);
    nextCycle();

    // reset lands in the same cycle as a load grant
    applyStimulus(1, 1'b1, 6'd30, 30'h5, 1'b0, 32'd0);
    #1;
    checkOutput("t7_pre_ready1", 32'(bus.req_ready[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t7_ready1_gated", 32'(bus.req_ready[1]), 32'd0);
    checkOutput("t7_bank_en1_gated", 32'(bus.bank_en[1]), 32'd0);
    checkOutput("t7_conflict0", 32'(conflict_cnt[0]), 32'd0);
    nextCycle();
    checkOutput("t7_resp_valid1", 32'(bus.resp_valid[1]), 32'd0);
    checkOutput("t7_conflict3", 32'(conflict_cnt[3]), 32'd0);
    applyStimulus(1, 1'b0, 6'd0, 30'd0, 1'b0, 32'd0);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("t7_resp_valid1_after", 32'(bus.resp_valid[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
